// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer:
// FSM state encoding, 7-segment glyphs {g..a}, digit slot indices and the BCD decoder.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timerState_e;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam int DIGIT_US = 0;
  localparam int DIGIT_DS = 1;
  localparam int DIGIT_UM = 2;
  localparam int DIGIT_DM = 3;

  // Non-BCD codes blank the digit; the count path never produces them.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit that wraps 0 -> MAX_VAL and flags a borrow to the next digit.
module bcd_digit_down #(
  parameter int MAX_VAL = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] loadVal,
  input  logic       dec,
  output logic [3:0] value,
  output logic       borrow
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      value <= '0;
    else if (clr)
      value <= '0;
    else if (load)
      value <= loadVal;
    else if (dec)
      value <= (value == 4'd0) ? 4'(MAX_VAL) : value - 4'd1;
  end

  assign borrow = dec && (value == 4'd0);

endmodule

// File: rtl/rega_countdown_timer.sv
// MM:SS BCD countdown with load/start/pause/clear control, 1 s prescaler and scanned 7-seg output.
// Define TIMER_AUTO_RELOAD_EN to reload the last loaded preset on reaching 00:00 instead of stopping.
module rega_countdown_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000,
  parameter int MAX_MIN  = 99
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] preset_bcd,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  output logic [15:0] time_bcd,
  output logic        running,
  output logic        done,
  output logic [6:0]  seg,
  output logic [3:0]  digit_en
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
  localparam logic [7:0]        MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

  timerState_e       state, stateNext;
  logic [PRE_W-1:0]  prescaler;
  logic [SCAN_W-1:0] scanCnt;
  logic [1:0]        scanIdx, scanIdxNext;
  logic [3:0]        clampDm, clampUm, clampDs, clampUs;
  logic [15:0]       clampedPreset, reloadVal, digLoadVal;
  logic [3:0]        digDec, borrow;
  logic              tick, timeZero, timeOne, startOk, reachZero, reloadNow, digLoad;

  assign timeZero  = (time_bcd == 16'h0000);
  assign timeOne   = (time_bcd == 16'h0001);
  assign tick      = (state == RUN) && (prescaler == PRE_LAST);
  assign startOk   = start && !pause && !load && !clear && !timeZero;
  assign reachZero = tick && timeOne && !load && !clear;
  assign running   = (state == RUN);

  always_comb begin
    clampDm = (preset_bcd[15:12] > 4'd9) ? 4'd9 : preset_bcd[15:12];
    clampUm = (preset_bcd[11:8]  > 4'd9) ? 4'd9 : preset_bcd[11:8];
    clampDs = (preset_bcd[7:4]   > 4'd5) ? 4'd5 : preset_bcd[7:4];
    clampUs = (preset_bcd[3:0]   > 4'd9) ? 4'd9 : preset_bcd[3:0];
    if ({clampDm, clampUm} > MAX_MIN_BCD)
      {clampDm, clampUm} = MAX_MIN_BCD;
    clampedPreset = {clampDm, clampUm, clampDs, clampUs};
  end

`ifdef TIMER_AUTO_RELOAD_EN
  logic [15:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      shadow <= '0;
    else if (load && !clear)
      shadow <= clampedPreset;
  end

  assign reloadNow = reachZero && (shadow != 16'h0000);
  assign reloadVal = shadow;
`else
  assign reloadNow = 1'b0;
  assign reloadVal = 16'h0000;
`endif

  assign digLoad    = (load && !clear) || reloadNow;
  assign digLoadVal = (load && !clear) ? clampedPreset : reloadVal;
  assign digDec     = {borrow[DIGIT_UM], borrow[DIGIT_DS], borrow[DIGIT_US], tick && !timeZero};

  bcd_digit_down #(.MAX_VAL(9)) uDigitUs (
    .clk, .rst_n, .clr(clear), .load(digLoad), .loadVal(digLoadVal[DIGIT_US*4 +: 4]),
    .dec(digDec[DIGIT_US]), .value(time_bcd[DIGIT_US*4 +: 4]), .borrow(borrow[DIGIT_US])
  );
  bcd_digit_down #(.MAX_VAL(5)) uDigitDs (
    .clk, .rst_n, .clr(clear), .load(digLoad), .loadVal(digLoadVal[DIGIT_DS*4 +: 4]),
    .dec(digDec[DIGIT_DS]), .value(time_bcd[DIGIT_DS*4 +: 4]), .borrow(borrow[DIGIT_DS])
  );
  bcd_digit_down #(.MAX_VAL(9)) uDigitUm (
    .clk, .rst_n, .clr(clear), .load(digLoad), .loadVal(digLoadVal[DIGIT_UM*4 +: 4]),
    .dec(digDec[DIGIT_UM]), .value(time_bcd[DIGIT_UM*4 +: 4]), .borrow(borrow[DIGIT_UM])
  );
  bcd_digit_down #(.MAX_VAL(9)) uDigitDm (
    .clk, .rst_n, .clr(clear), .load(digLoad), .loadVal(digLoadVal[DIGIT_DM*4 +: 4]),
    .dec(digDec[DIGIT_DM]), .value(time_bcd[DIGIT_DM*4 +: 4]), .borrow(borrow[DIGIT_DM])
  );

  // Resuming from PAUSE keeps the partial second; a fresh start from IDLE begins a full one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      prescaler <= '0;
    else if (clear || load)
      prescaler <= '0;
    else if (state == IDLE && startOk)
      prescaler <= '0;
    else if (state == RUN)
      prescaler <= tick ? '0 : prescaler + PRE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (clear || load)
      stateNext = IDLE;
    else begin
      case (state)
        IDLE, PAUSE: if (startOk) stateNext = RUN;
        RUN: begin
          if (reachZero && !reloadNow)
            stateNext = DONE;
          else if (pause)
            stateNext = PAUSE;
        end
        DONE:    stateNext = DONE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // A DM borrow would mean an underflow past 00:00, which must never be reported as done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      done <= 1'b0;
    else
      done <= reachZero && !borrow[DIGIT_DM];
  end

  assign scanIdxNext = (scanCnt == SCAN_LAST) ? scanIdx + 2'd1 : scanIdx;

  // Enable and segments are registered together so the glyph always matches the lit digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scanCnt  <= '0;
      scanIdx  <= 2'd0;
      digit_en <= 4'b0001;
      seg      <= SEG_0;
    end else begin
      scanCnt  <= (scanCnt == SCAN_LAST) ? '0 : scanCnt + SCAN_W'(1);
      scanIdx  <= scanIdxNext;
      digit_en <= 4'b0001 << scanIdxNext;
      seg      <= bcd_to_seg(time_bcd[{scanIdxNext, 2'b00} +: 4]);
    end
  end

endmodule

// File: tb/tb_rega_countdown_timer.sv
// Randomised self-checking bench for rega_countdown_timer against a seconds-based reference model.
module tb_rega_countdown_timer;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 3;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
`ifdef TIMER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [15:0] preset_bcd = '0;
  logic [15:0] time_bcd, time45;
  logic        running, done, running45, done45;
  logic [6:0]  seg, seg45;
  logic [3:0]  digit_en, digitEn45;

  int nVec = 0, nMis = 0;
  int mSec = 0, mPre = 0, mState = S_IDLE, mShadow = 0, edgeCnt = 0;
  bit mDone = 1'b0;
  logic [15:0] prevBcd = '0;
  logic [6:0] segTab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  rega_countdown_timer #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .MAX_MIN(99)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .preset_bcd(preset_bcd), .start(start),
    .pause(pause), .clear(clear), .time_bcd(time_bcd), .running(running), .done(done),
    .seg(seg), .digit_en(digit_en)
  );

  rega_countdown_timer #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .MAX_MIN(45)) dut45 (
    .clk(clk), .rst_n(rst_n), .load(load), .preset_bcd(preset_bcd), .start(start),
    .pause(pause), .clear(clear), .time_bcd(time45), .running(running45), .done(done45),
    .seg(seg45), .digit_en(digitEn45)
  );

  always #5 clk = ~clk;

  function automatic int clampSec(logic [15:0] p, int maxMin);
    int dm, um, ds, us, m;
    dm = (p[15:12] > 9) ? 9 : int'(p[15:12]);
    um = (p[11:8]  > 9) ? 9 : int'(p[11:8]);
    ds = (p[7:4]   > 5) ? 5 : int'(p[7:4]);
    us = (p[3:0]   > 9) ? 9 : int'(p[3:0]);
    m  = dm * 10 + um;
    if (m > maxMin) m = maxMin;
    return m * 60 + ds * 10 + us;
  endfunction

  function automatic logic [15:0] toBcd(int sec);
    int m, s;
    m = sec / 60;
    s = sec % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Reference behaviour for one clock edge, expressed in whole seconds remaining.
  function automatic void stepModel(bit ld, logic [15:0] pr, bit st, bit ps, bit cl);
    bit tick;
    mDone = 1'b0;
    if (cl) begin
      mState = S_IDLE; mSec = 0; mPre = 0;
    end else if (ld) begin
      mSec = clampSec(pr, 99); mShadow = mSec; mPre = 0; mState = S_IDLE;
    end else if (mState == S_RUN) begin
      tick = (mPre == TICK_DIV - 1);
      mPre = tick ? 0 : mPre + 1;
      if (tick) begin
        mSec = mSec - 1;
        if (mSec == 0) begin
          mDone = 1'b1;
          if (AUTO && mShadow > 0) mSec = mShadow;
          else mState = S_DONE;
        end
      end
      if (ps && mState == S_RUN) mState = S_PAUSE;
    end else if (!ps && st && (mState == S_IDLE || mState == S_PAUSE) && mSec != 0) begin
      if (mState == S_IDLE) mPre = 0;
      mState = S_RUN;
    end
  endfunction

  task automatic doCycle(bit ld, logic [15:0] pr, bit st, bit ps, bit cl);
    load = ld; preset_bcd = pr; start = st; pause = ps; clear = cl;
    prevBcd = toBcd(mSec);
    @(posedge clk);
    stepModel(ld, pr, st, ps, cl);
    edgeCnt++;
    #1;
    load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    mSec = 0; mPre = 0; mState = S_IDLE; mShadow = 0; mDone = 1'b0; edgeCnt = 0;
  endtask

  task automatic test_reset();
    resetDut();
    doCycle(1'b1, 16'h0130, 1'b0, 1'b0, 1'b0);
    doCycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    repeat (6) doCycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    nVec++; if (running !== 1'b1) begin nMis++; $display("[TB] FAIL reset pre-run running: got %b want 1", running); end
    nVec++; if (time_bcd !== 16'h0129) begin nMis++; $display("[TB] FAIL reset pre-run time: got %h want 0129", time_bcd); end
    rst_n = 1'b0;
    #2;
    nVec++; if (time_bcd !== 16'h0000) begin nMis++; $display("[TB] FAIL reset time: got %h want 0000", time_bcd); end
    nVec++; if (running !== 1'b0) begin nMis++; $display("[TB] FAIL reset running: got %b want 0", running); end
    nVec++; if (done !== 1'b0) begin nMis++; $display("[TB] FAIL reset done: got %b want 0", done); end
    nVec++; if (digit_en !== 4'b0001) begin nMis++; $display("[TB] FAIL reset digit_en: got %b want 0001", digit_en); end
    nVec++; if (seg !== 7'h3F) begin nMis++; $display("[TB] FAIL reset seg: got %h want 3f", seg); end
    @(posedge clk); #1;
    nVec++; if (time_bcd !== 16'h0000) begin nMis++; $display("[TB] FAIL reset held time: got %h want 0000", time_bcd); end
    @(negedge clk);
    rst_n = 1'b1;
    mSec = 0; mPre = 0; mState = S_IDLE; mShadow = 0; mDone = 1'b0; edgeCnt = 0;
  endtask

  task automatic test_countdown();
    doCycle(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    doCycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      doCycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      nVec++; if (time_bcd !== toBcd(mSec)) begin nMis++; $display("[TB] FAIL countdown time c%0d: got %h want %h", i, time_bcd, toBcd(mSec)); end
      nVec++; if (running !== (mState == S_RUN)) begin nMis++; $display("[TB] FAIL countdown running c%0d: got %b want %b", i, running, mState == S_RUN); end
      nVec++; if (done !== mDone) begin nMis++; $display("[TB] FAIL countdown done c%0d: got %b want %b", i, done, mDone); end
      if (i == 12) begin
        nVec++; if (done !== 1'b1 || time_bcd !== 16'h0000) begin nMis++; $display("[TB] FAIL countdown end: got done %b time %h want 1 0000", done, time_bcd); end
      end
    end
  endtask

  task automatic test_borrow();
    doCycle(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
    doCycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    repeat (TICK_DIV) doCycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    nVec++; if (time_bcd !== 16'h0959) begin nMis++; $display("[TB] FAIL borrow time: got %h want 0959", time_bcd); end
    nVec++; if (time_bcd !== toBcd(mSec)) begin nMis++; $display("[TB] FAIL borrow model: got %h want %h", time_bcd, toBcd(mSec)); end
  endtask

  task automatic test_clamp();
    logic [15:0] pr;
    doCycle(1'b1, 16'h9F7A, 1'b0, 1'b0, 1'b0);
    nVec++; if (time_bcd !== 16'h9959) begin nMis++; $display("[TB] FAIL clamp99 9F7A: got %h want 9959", time_bcd); end
    nVec++; if (time45 !== 16'h4559) begin nMis++; $display("[TB] FAIL clamp45 9F7A: got %h want 4559", time45); end
    for (int i = 0; i < 10; i++) begin
      pr = 16'($urandom);
      doCycle(1'b1, pr, 1'b0, 1'b0, 1'b0);
      nVec++; if (time_bcd !== toBcd(clampSec(pr, 99))) begin nMis++; $display("[TB] FAIL clamp99 %h: got %h want %h", pr, time_bcd, toBcd(clampSec(pr, 99))); end
      nVec++; if (time45 !== toBcd(clampSec(pr, 45))) begin nMis++; $display("[TB] FAIL clamp45 %h: got %h want %h", pr, time45, toBcd(clampSec(pr, 45))); end
    end
  endtask

  task automatic test_pause();
    doCycle(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    doCycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    repeat (6) doCycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    doCycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2 * TICK_DIV; i++) begin
      doCycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      nVec++; if (time_bcd !== 16'h0004 || running !== 1'b0) begin nMis++; $display("[TB] FAIL pause hold c%0d: got %h run %b want 0004 run 0", i, time_bcd, running); end
    end
    doCycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      doCycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      nVec++; if (time_bcd !== toBcd(mSec)) begin nMis++; $display("[TB] FAIL resume time c%0d: got %h want %h", i, time_bcd, toBcd(mSec)); end
      nVec++; if (done !== mDone) begin nMis++; $display("[TB] FAIL resume done c%0d: got %b want %b", i, done, mDone); end
    end
  endtask

  task automatic test_priority();
    doCycle(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    doCycle(1'b1, 16'h0542, 1'b1, 1'b0, 1'b1);
    nVec++; if (time_bcd !== 16'h0000 || running !== 1'b0) begin nMis++; $display("[TB] FAIL prio clear: got %h run %b want 0000 run 0", time_bcd, running); end
    for (int i = 0; i < 6; i++) begin
      doCycle(1'b0, 16'h0000, (i < 2), 1'b0, 1'b0);
      nVec++; if (time_bcd !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin nMis++; $display("[TB] FAIL prio start-at-zero c%0d: got %h run %b done %b want 0000 0 0", i, time_bcd, running, done); end
    end
    doCycle(1'b1, 16'h0021, 1'b1, 1'b1, 1'b0);
    nVec++; if (time_bcd !== 16'h0021 || running !== 1'b0) begin nMis++; $display("[TB] FAIL prio load: got %h run %b want 0021 run 0", time_bcd, running); end
  endtask

  task automatic test_display();
    int slot;
    resetDut();
    doCycle(1'b1, 16'h1207, 1'b0, 1'b0, 1'b0);
    doCycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      doCycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      slot = (edgeCnt / SCAN_DIV) % 4;
      nVec++; if (digit_en !== (4'b0001 << slot)) begin nMis++; $display("[TB] FAIL display digit_en c%0d: got %b want %b", i, digit_en, 4'b0001 << slot); end
      nVec++; if (seg !== segTab[prevBcd[slot*4 +: 4]]) begin nMis++; $display("[TB] FAIL display seg c%0d: got %h want %h", i, seg, segTab[prevBcd[slot*4 +: 4]]); end
    end
  endtask

  task automatic test_random();
    logic [15:0] pr;
    bit ld, st, ps, cl;
    for (int i = 0; i < 400; i++) begin
      cl = ($urandom_range(0, 99) < 1);
      ld = ($urandom_range(0, 99) < 4);
      ps = ($urandom_range(0, 99) < 3);
      st = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 1) == 0) pr = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      else pr = 16'($urandom);
      doCycle(ld, pr, st, ps, cl);
      nVec++; if (time_bcd !== toBcd(mSec)) begin nMis++; $display("[TB] FAIL random time c%0d: got %h want %h", i, time_bcd, toBcd(mSec)); end
      nVec++; if (running !== (mState == S_RUN)) begin nMis++; $display("[TB] FAIL random running c%0d: got %b want %b", i, running, mState == S_RUN); end
      nVec++; if (done !== mDone) begin nMis++; $display("[TB] FAIL random done c%0d: got %b want %b", i, done, mDone); end
    end
  endtask

`ifdef TIMER_AUTO_RELOAD_EN
  task automatic test_autoreload();
    doCycle(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    doCycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      doCycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      nVec++; if (time_bcd !== toBcd(mSec)) begin nMis++; $display("[TB] FAIL reload time c%0d: got %h want %h", i, time_bcd, toBcd(mSec)); end
      nVec++; if (running !== 1'b1) begin nMis++; $display("[TB] FAIL reload running c%0d: got %b want 1", i, running); end
      nVec++; if (done !== mDone) begin nMis++; $display("[TB] FAIL reload done c%0d: got %b want %b", i, done, mDone); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_clamp();
    test_pause();
    test_priority();
    test_display();
    test_random();
`ifdef TIMER_AUTO_RELOAD_EN
    test_autoreload();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
